keypad_scanner: RTL
===================

# keypad_scanner

Parametrised matrix-keypad scanner with per-scan debounce, press/release event generation and a buffered valid/ready output. It drives the keypad row lines, samples the column lines and qualifies a stable key over several full scans. Each press and release is pushed as an event word into a small FIFO, which the downstream consumer drains at its own pace. The block replaces single-pulse 4x4 key reading in the input path.

## Interface
- `ROWS`, default 4: number of row lines, ≥2.
- `COLS`, default 4: number of column lines, ≥2.
- `SCAN_DIV`, default 1000: clock cycles each row is driven (dwell), ≥2.
- `DEBOUNCE_SCANS`, default 4: consecutive identical full scans needed to commit, ≥1.
- `FIFO_DEPTH`, default 4: event FIFO entries, power of 2, ≥2.
- `REPEAT_DELAY`, default 50: scans of hold before first auto-repeat (used only with macro).
- `REPEAT_RATE`, default 10: scans between auto-repeats (used only with macro).
- Local width: CW = max(1, $clog2(ROWS*COLS)).
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `filas` out ROWS: row drive, one line low at a time.
- `columnas` in COLS: column sense, active-low, externally pulled up.
- `key_event` out CW+1: FIFO head, {release, code}.
- `key_valid` out 1: FIFO not empty.
- `key_ready` in 1: consumer accepts head.
- `key_down` out 1: a debounced key is currently held.
- `overflow` out 1: sticky, an event was dropped.
- `clr_overflow` in 1: clears `overflow`.

## Operation
- Code = row*COLS + col; raw index, no character mapping.
- FSM states:
  - DWELL: drive row r; count to SCAN_DIV-2; then go to SAMPLE.
  - SAMPLE: latch `columnas` into snapshot row r, one cycle. If r<ROWS-1, r++ and go to DWELL; else go to COMMIT.
  - COMMIT: one cycle, evaluate scan; set r=0; go to DWELL.
- Scan period is ROWS*SCAN_DIV+1 cycles.
- Candidate = lowest-index pressed bit in the snapshot, or NONE. Multiple keys held resolve to the lowest index.
- Debounce: if candidate equals the previous scan's candidate, increment `deb_cnt` (saturating); else set `deb_cnt`=1. Candidate qualifies when `deb_cnt` ≥ DEBOUNCE_SCANS.
- On qualify, compare against stable key S:
  - NONE→K: push {0,K}; S=K.
  - K→NONE: push {1,K}; S=NONE.
  - K→J: push {1,K}; S=NONE. J commits as a press on the next COMMIT, because its count is already satisfied.
  - At most one push per COMMIT.
- `key_down` = (S≠NONE).
- FIFO:
  - Pop when `key_valid`&`key_ready`.
  - Push while full without a simultaneous pop: event dropped, `overflow` set.
  - Push while full with a simultaneous pop: event accepted.
- `overflow` clears on `clr_overflow` unless a drop occurs in the same cycle; set wins.

## Timing
- Reset values:
  - `filas` = all ones except bit0 low.
  - FSM in DWELL with r=0 and counters 0.
  - S=NONE; `deb_cnt`=0; FIFO empty.
  - `key_valid`=0, `key_event`=0, `key_down`=0, `overflow`=0.
- `filas` changes in the cycle after SAMPLE.
- Columns are sampled SCAN_DIV-1 cycles after the row is asserted, for settling.
- Push occurs on the COMMIT edge. `key_valid` and `key_event` update the following cycle.
- Press latency: DEBOUNCE_SCANS COMMITs after the first scan that sees the key, plus 1 cycle.
- `key_event` holds stable while `key_valid`=1 and `key_ready`=0.
- Reset mid-scan or with events pending: FIFO flushed, no release event emitted.

## Configuration
- `KEYPAD_AUTOREPEAT_EN` defined:
  - While S=K, a hold counter increments each COMMIT.
  - Push {0,K} when the counter reaches REPEAT_DELAY, then every REPEAT_RATE scans after that.
  - The counter resets on any change of S.
  - Repeats obey the FIFO overflow rules.
- Not defined: exactly one press event per hold; the REPEAT_* parameters are ignored and no hold counter is synthesised.

## Test plan
- ROWS=COLS=4, SCAN_DIV=8, DEBOUNCE_SCANS=2. Hold row1/col1 for 10 scans, then release. Required: one {0,5}, then one {1,5}, with `key_down` high in between.
- Bounce col2 on row0 alternating every scan for 6 scans. Required: no event, `key_down`=0.
- Hold codes 6 and 9 together. Required: {0,6} only. Release 6 while holding 9: required {1,6}, then {0,9} on the next COMMIT.
- `key_ready`=0 and 5 press/release events with FIFO_DEPTH=4. Required: 4 stored in order, `overflow`=1. Drain, then `clr_overflow`: required `overflow`=0.
- Push and pop in the same cycle while full. Required: no drop, count unchanged.
- With `KEYPAD_AUTOREPEAT_EN`, REPEAT_DELAY=3, REPEAT_RATE=2, hold code 0 for 9 scans. Required: {0,0} at commit, then repeats at hold 3, 5 and 7. Assert `rst_n` mid-hold: required all outputs return to reset values.

Source files
------------

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: row strobing, scan-level debounce, press/release events into a FIFO.
// Define KEYPAD_AUTOREPEAT_EN to add auto-repeat press events for a held key.
module keypad_scanner #(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter int REPEAT_DELAY   = 50,
  parameter int REPEAT_RATE    = 10,
  localparam int CW = ($clog2(ROWS*COLS) > 1) ? $clog2(ROWS*COLS) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [ROWS-1:0] filas,
  input  logic [COLS-1:0] columnas,
  output logic [CW:0]     key_event,
  output logic            key_valid,
  input  logic            key_ready,
  output logic            key_down,
  output logic            overflow,
  input  logic            clr_overflow
);

  localparam int NK = ROWS * COLS;
  localparam int RW = ($clog2(ROWS) > 1) ? $clog2(ROWS) : 1;
  localparam int VW = ($clog2(SCAN_DIV) > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] ST_DWELL  = 2'd0;
  localparam logic [1:0] ST_SAMPLE = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  if (ROWS < 2 || COLS < 2 || SCAN_DIV < 2 || DEBOUNCE_SCANS < 1 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_param
    $error("keypad_scanner: illegal parameter set");
  end

  logic [1:0]      state_q, state_d;
  logic [RW-1:0]   row_q, row_d;
  logic [VW-1:0]   div_q, div_d;
  logic [NK-1:0]   snap_q, snap_d;
  logic [ROWS-1:0] filas_q, filas_d;
  logic            commit;

  logic            cand_v;
  logic [CW-1:0]   cand_code;
  logic            prev_v_q, prev_v_d;
  logic [CW-1:0]   prev_code_q, prev_code_d;
  logic [DW-1:0]   deb_q, deb_d, deb_inc, deb_new;
  logic            same, qual;
  logic            stab_v_q, stab_v_d;
  logic [CW-1:0]   stab_code_q, stab_code_d;
  logic            push;
  logic [CW:0]     push_data;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    div_d   = div_q;
    snap_d  = snap_q;
    commit  = 1'b0;
    case (state_q)
      ST_DWELL: begin
        if (div_q == VW'(SCAN_DIV - 2)) begin
          div_d   = '0;
          state_d = ST_SAMPLE;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_SAMPLE: begin
        for (int r = 0; r < ROWS; r++) begin
          if (row_q == RW'(r)) snap_d[r*COLS +: COLS] = ~columnas;
        end
        if (row_q == RW'(ROWS - 1)) begin
          state_d = ST_COMMIT;
        end else begin
          row_d   = row_q + 1'b1;
          state_d = ST_DWELL;
        end
      end
      ST_COMMIT: begin
        commit  = 1'b1;
        row_d   = '0;
        state_d = ST_DWELL;
      end
      default: state_d = ST_DWELL;
    endcase
    filas_d = ~(ROWS'(1) << row_d);
  end

  // Lowest pressed index wins when several keys are held.
  always_comb begin
    cand_v    = 1'b0;
    cand_code = '0;
    for (int i = NK - 1; i >= 0; i--) begin
      if (snap_q[i]) begin
        cand_v    = 1'b1;
        cand_code = CW'(i);
      end
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int HW  = $clog2(REPEAT_DELAY + 1);
  localparam int RTW = $clog2(REPEAT_RATE + 1);
  logic [HW-1:0]  hold_q, hold_d;
  logic [RTW-1:0] rate_q, rate_d;
`endif

  always_comb begin
    same        = (cand_v == prev_v_q) && (cand_code == prev_code_q);
    deb_inc     = (deb_q < DW'(DEBOUNCE_SCANS)) ? deb_q + 1'b1 : deb_q;
    deb_new     = same ? deb_inc : DW'(1);
    qual        = (deb_new >= DW'(DEBOUNCE_SCANS));
    deb_d       = deb_q;
    prev_v_d    = prev_v_q;
    prev_code_d = prev_code_q;
    stab_v_d    = stab_v_q;
    stab_code_d = stab_code_q;
    push        = 1'b0;
    push_data   = '0;
    if (commit) begin
      deb_d       = deb_new;
      prev_v_d    = cand_v;
      prev_code_d = cand_code;
      if (qual) begin
        if (!stab_v_q && cand_v) begin
          push        = 1'b1;
          push_data   = {1'b0, cand_code};
          stab_v_d    = 1'b1;
          stab_code_d = cand_code;
        end else if (stab_v_q && (!cand_v || cand_code != stab_code_q)) begin
          // A different key first releases the old one; the new press follows next scan.
          push      = 1'b1;
          push_data = {1'b1, stab_code_q};
          stab_v_d  = 1'b0;
        end
      end
    end
`ifdef KEYPAD_AUTOREPEAT_EN
    hold_d = hold_q;
    rate_d = rate_q;
    if (commit) begin
      if (push) begin
        hold_d = '0;
        rate_d = '0;
      end else if (stab_v_q) begin
        if (hold_q < HW'(REPEAT_DELAY)) begin
          hold_d = hold_q + 1'b1;
          if (hold_q == HW'(REPEAT_DELAY - 1)) begin
            push      = 1'b1;
            push_data = {1'b0, stab_code_q};
            rate_d    = RTW'(REPEAT_RATE);
          end
        end else if (rate_q == RTW'(1)) begin
          push      = 1'b1;
          push_data = {1'b0, stab_code_q};
          rate_d    = RTW'(REPEAT_RATE);
        end else begin
          rate_d = rate_q - 1'b1;
        end
      end
    end
`endif
  end

  logic [CW:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          full, pop, wr_en, drop, ovf_q;

  assign full  = (cnt_q == (AW + 1)'(FIFO_DEPTH));
  assign pop   = key_valid & key_ready;
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  always_comb begin
    case ({wr_en, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_q] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_DWELL;
      row_q       <= '0;
      div_q       <= '0;
      snap_q      <= '0;
      filas_q     <= ~ROWS'(1);
      prev_v_q    <= 1'b0;
      prev_code_q <= '0;
      deb_q       <= '0;
      stab_v_q    <= 1'b0;
      stab_code_q <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      div_q       <= div_d;
      snap_q      <= snap_d;
      filas_q     <= filas_d;
      prev_v_q    <= prev_v_d;
      prev_code_q <= prev_code_d;
      deb_q       <= deb_d;
      stab_v_q    <= stab_v_d;
      stab_code_q <= stab_code_d;
      cnt_q       <= cnt_d;
      if (wr_en) wr_q <= wr_q + 1'b1;
      if (pop)   rd_q <= rd_q + 1'b1;
      if (drop)              ovf_q <= 1'b1;
      else if (clr_overflow) ovf_q <= 1'b0;
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      rate_q <= '0;
    end else begin
      hold_q <= hold_d;
      rate_q <= rate_d;
    end
  end
`endif

  assign filas     = filas_q;
  assign key_valid = (cnt_q != '0);
  assign key_event = key_valid ? mem[rd_q] : '0;
  assign key_down  = stab_v_q;
  assign overflow  = ovf_q;

endmodule
